// File: rtl/hqm_AW_pkg.sv
// Shared helpers for the HQM assertion models: integer log2 and the
// sticky-error bundle carried by each ordered-FIFO channel.
package hqm_AW_pkg;

  // floor(log2(x)); returns 0 for x <= 1
  function automatic int AW_logb2(input int x);
    int r;
    r = 0;
    for (int v = x; v > 1; v = v >> 1) r++;
    return r;
  endfunction

  typedef struct packed {
    logic ovf;
    logic udf;
    logic unwr;
    logic addr;
  } hqm_assertion_ofifo_err_t;

endpackage

// File: rtl/hqm_assertion_mc_ofifo_ch.sv
// One ordered-FIFO channel: push/pop, init/append reservation, write-by-address,
// watermarks, peak occupancy and sticky errors. DEPTH may be any value >= 2.
module hqm_assertion_mc_ofifo_ch
  import hqm_AW_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DWIDTH     = 16,
  parameter int AWIDTH     = AW_logb2(DEPTH-1)+1,
  parameter int DEPTHWIDTH = AW_logb2(DEPTH)+1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DEPTHWIDTH-1:0] low_wm,
  input  logic [DEPTHWIDTH-1:0] high_wm,
  input  logic                  push,
  input  logic [DWIDTH-1:0]     push_data,
  input  logic                  pop,
  output logic [DWIDTH-1:0]     pop_data,
  output logic                  pop_v,
  input  logic                  init,
  input  logic [DEPTHWIDTH-1:0] init_amount,
  input  logic                  append,
  input  logic [DEPTHWIDTH-1:0] append_amount,
  input  logic                  write,
  input  logic [AWIDTH-1:0]     write_addr,
  input  logic [DWIDTH-1:0]     write_data,
  input  logic                  err_clr,
  output logic                  empty,
  output logic                  full,
  output logic                  aempty,
  output logic                  afull,
  output logic [DEPTHWIDTH-1:0] fifo_depth,
  output logic [DEPTHWIDTH-1:0] peak_depth,
  output logic [AWIDTH-1:0]     rp,
  output logic [AWIDTH-1:0]     wp,
  output logic                  err_ovf,
  output logic                  err_udf,
  output logic                  err_unwr,
  output logic                  err_addr
);

  localparam logic [DEPTHWIDTH-1:0] DEPTH_C = DEPTHWIDTH'(DEPTH);
  localparam logic [DEPTHWIDTH:0]   DEPTH_E = (DEPTHWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH-1:0]     LAST_A  = AWIDTH'(DEPTH-1);

  function automatic logic [AWIDTH-1:0] ptr_inc(input logic [AWIDTH-1:0] p);
    return (p == LAST_A) ? '0 : p + 1'b1;
  endfunction

  // (p + amt) mod DEPTH without a divider; amt < 2*DEPTH so two folds suffice
  function automatic logic [AWIDTH-1:0] ptr_add(input logic [AWIDTH-1:0] p,
                                                input logic [DEPTHWIDTH-1:0] amt);
    logic [DEPTHWIDTH:0] s;
    s = (DEPTHWIDTH+1)'(p) + (DEPTHWIDTH+1)'(amt);
    if (s >= DEPTH_E) s = s - DEPTH_E;
    if (s >= DEPTH_E) s = s - DEPTH_E;
    return s[AWIDTH-1:0];
  endfunction

  logic [DWIDTH-1:0]        mem_q [DEPTH];
  logic [DWIDTH-1:0]        mem_d [DEPTH];
  logic [DEPTH-1:0]         v_q, v_d;
  logic [AWIDTH-1:0]        rp_q, rp_d, wp_q, wp_d;
  logic [DEPTHWIDTH-1:0]    cnt_q, cnt_d, peak_q, peak_d, peak_base;
  hqm_assertion_ofifo_err_t err_q, err_d, ev;
  logic                     pop_ok, push_ok;
  logic [DEPTHWIDTH:0]      app_sum;

  always_comb begin
    pop_ok  = pop && (cnt_q != '0);
    push_ok = push && ((cnt_q != DEPTH_C) || pop_ok);
    rp_d    = rp_q;
    wp_d    = wp_q;
    cnt_d   = cnt_q;
    v_d     = v_q;
    mem_d   = mem_q;
    ev      = '0;
    app_sum = '0;
    if (init) begin
      rp_d   = '0;
      wp_d   = ptr_add('0, init_amount);
      cnt_d  = (init_amount > DEPTH_C) ? DEPTH_C : init_amount;
      v_d    = '0;
      ev.ovf = (init_amount > DEPTH_C);
    end else begin
      // pop clears before push sets: when full, rp == wp and both touch one slot
      if (pop_ok) begin
        v_d[rp_q] = 1'b0;
        rp_d      = ptr_inc(rp_q);
        ev.unwr   = !v_q[rp_q];
      end else begin
        ev.udf = pop;
      end
      if (push_ok) begin
        mem_d[wp_q] = push_data;
        v_d[wp_q]   = 1'b1;
        wp_d        = ptr_inc(wp_q);
      end else begin
        ev.ovf = push;
      end
      cnt_d   = cnt_q + DEPTHWIDTH'(push_ok) - DEPTHWIDTH'(pop_ok);
      app_sum = {1'b0, cnt_d} + {1'b0, append_amount};
      if (append) begin
        if (app_sum <= DEPTH_E) begin
          wp_d  = ptr_add(wp_d, append_amount);
          cnt_d = app_sum[DEPTHWIDTH-1:0];
        end else begin
          ev.ovf = 1'b1;
        end
      end
    end
    if (write) begin
      if ((DEPTHWIDTH+1)'(write_addr) < DEPTH_E) begin
        mem_d[write_addr] = write_data;
        v_d[write_addr]   = 1'b1;
      end else begin
        ev.addr = 1'b1;
      end
    end
    peak_base = init ? '0 : peak_q;
    peak_d    = (cnt_d > peak_base) ? cnt_d : peak_base;
    err_d     = hqm_assertion_ofifo_err_t'((err_q & {4{~err_clr}}) | ev);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q  <= '{default: '0};
      v_q    <= '0;
      rp_q   <= '0;
      wp_q   <= '0;
      cnt_q  <= '0;
      peak_q <= '0;
      err_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      v_q    <= v_d;
      rp_q   <= rp_d;
      wp_q   <= wp_d;
      cnt_q  <= cnt_d;
      peak_q <= peak_d;
      err_q  <= err_d;
    end
  end

  assign pop_data   = mem_q[rp_q];
  assign pop_v      = v_q[rp_q] & (cnt_q != '0);
  assign empty      = (cnt_q == '0);
  assign full       = (cnt_q == DEPTH_C);
  assign aempty     = (cnt_q <= low_wm);
  assign afull      = (cnt_q >= high_wm);
  assign fifo_depth = cnt_q;
  assign peak_depth = peak_q;
  assign rp         = rp_q;
  assign wp         = wp_q;
  assign err_ovf    = err_q.ovf;
  assign err_udf    = err_q.udf;
  assign err_unwr   = err_q.unwr;
  assign err_addr   = err_q.addr;

endmodule

// File: rtl/hqm_assertion_mc_ofifo.sv
// Multi-channel ordered-FIFO reference model: NUM_CH independent channels,
// each a hqm_assertion_mc_ofifo_ch, with channel-major flattened buses.
module hqm_assertion_mc_ofifo
  import hqm_AW_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DEPTH      = 8,
  parameter int DWIDTH     = 16,
  parameter int AWIDTH     = AW_logb2(DEPTH-1)+1,
  parameter int DEPTHWIDTH = AW_logb2(DEPTH)+1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DEPTHWIDTH-1:0]        low_wm,
  input  logic [DEPTHWIDTH-1:0]        high_wm,
  input  logic [NUM_CH-1:0]            push,
  input  logic [NUM_CH*DWIDTH-1:0]     push_data,
  input  logic [NUM_CH-1:0]            pop,
  output logic [NUM_CH*DWIDTH-1:0]     pop_data,
  output logic [NUM_CH-1:0]            pop_v,
  input  logic [NUM_CH-1:0]            init,
  input  logic [NUM_CH*DEPTHWIDTH-1:0] init_amount,
  input  logic [NUM_CH-1:0]            append,
  input  logic [NUM_CH*DEPTHWIDTH-1:0] append_amount,
  input  logic [NUM_CH-1:0]            write,
  input  logic [NUM_CH*AWIDTH-1:0]     write_addr,
  input  logic [NUM_CH*DWIDTH-1:0]     write_data,
  input  logic [NUM_CH-1:0]            err_clr,
  output logic [NUM_CH-1:0]            empty,
  output logic [NUM_CH-1:0]            full,
  output logic [NUM_CH-1:0]            aempty,
  output logic [NUM_CH-1:0]            afull,
  output logic [NUM_CH*DEPTHWIDTH-1:0] fifo_depth,
  output logic [NUM_CH*DEPTHWIDTH-1:0] peak_depth,
  output logic [NUM_CH*AWIDTH-1:0]     rp,
  output logic [NUM_CH*AWIDTH-1:0]     wp,
  output logic [NUM_CH-1:0]            err_ovf,
  output logic [NUM_CH-1:0]            err_udf,
  output logic [NUM_CH-1:0]            err_unwr,
  output logic [NUM_CH-1:0]            err_addr
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    hqm_assertion_mc_ofifo_ch #(
      .DEPTH      (DEPTH),
      .DWIDTH     (DWIDTH),
      .AWIDTH     (AWIDTH),
      .DEPTHWIDTH (DEPTHWIDTH)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .low_wm        (low_wm),
      .high_wm       (high_wm),
      .push          (push[c]),
      .push_data     (push_data[c*DWIDTH +: DWIDTH]),
      .pop           (pop[c]),
      .pop_data      (pop_data[c*DWIDTH +: DWIDTH]),
      .pop_v         (pop_v[c]),
      .init          (init[c]),
      .init_amount   (init_amount[c*DEPTHWIDTH +: DEPTHWIDTH]),
      .append        (append[c]),
      .append_amount (append_amount[c*DEPTHWIDTH +: DEPTHWIDTH]),
      .write         (write[c]),
      .write_addr    (write_addr[c*AWIDTH +: AWIDTH]),
      .write_data    (write_data[c*DWIDTH +: DWIDTH]),
      .err_clr       (err_clr[c]),
      .empty         (empty[c]),
      .full          (full[c]),
      .aempty        (aempty[c]),
      .afull         (afull[c]),
      .fifo_depth    (fifo_depth[c*DEPTHWIDTH +: DEPTHWIDTH]),
      .peak_depth    (peak_depth[c*DEPTHWIDTH +: DEPTHWIDTH]),
      .rp            (rp[c*AWIDTH +: AWIDTH]),
      .wp            (wp[c*AWIDTH +: AWIDTH]),
      .err_ovf       (err_ovf[c]),
      .err_udf       (err_udf[c]),
      .err_unwr      (err_unwr[c]),
      .err_addr      (err_addr[c])
    );
  end

endmodule

// File: tb/tb_hqm_assertion_mc_ofifo.sv
// Directed bench for hqm_assertion_mc_ofifo with NUM_CH=2, DEPTH=5, DWIDTH=8.
module tb_hqm_assertion_mc_ofifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  low_wm, high_wm;
  logic [1:0]  push, pop, init, append, write, err_clr;
  logic [15:0] push_data, write_data;
  logic [5:0]  init_amount, append_amount, write_addr;
  logic [15:0] pop_data;
  logic [1:0]  pop_v, empty, full, aempty, afull;
  logic [5:0]  fifo_depth, peak_depth, rp, wp;
  logic [1:0]  err_ovf, err_udf, err_unwr, err_addr;

  int total = 0;
  int bad   = 0;

  hqm_assertion_mc_ofifo #(.NUM_CH(2), .DEPTH(5), .DWIDTH(8)) dut (
    .clk(clk), .rst(rst), .low_wm(low_wm), .high_wm(high_wm),
    .push(push), .push_data(push_data), .pop(pop), .pop_data(pop_data), .pop_v(pop_v),
    .init(init), .init_amount(init_amount), .append(append), .append_amount(append_amount),
    .write(write), .write_addr(write_addr), .write_data(write_data), .err_clr(err_clr),
    .empty(empty), .full(full), .aempty(aempty), .afull(afull),
    .fifo_depth(fifo_depth), .peak_depth(peak_depth), .rp(rp), .wp(wp),
    .err_ovf(err_ovf), .err_udf(err_udf), .err_unwr(err_unwr), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pd(input int ch);  return pop_data[ch*8 +: 8];   endfunction
  function automatic logic [2:0] fd(input int ch);  return fifo_depth[ch*3 +: 3]; endfunction
  function automatic logic [2:0] pk(input int ch);  return peak_depth[ch*3 +: 3]; endfunction
  function automatic logic [2:0] rpv(input int ch); return rp[ch*3 +: 3];         endfunction
  function automatic logic [2:0] wpv(input int ch); return wp[ch*3 +: 3];         endfunction

  task automatic clr_strobes();
    push = '0; pop = '0; init = '0; append = '0; write = '0; err_clr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr_strobes();
  endtask

  task automatic do_push(input int ch, input logic [7:0] d);
    push[ch] = 1'b1;
    push_data[ch*8 +: 8] = d;
  endtask

  task automatic do_write(input int ch, input logic [2:0] a, input logic [7:0] d);
    write[ch] = 1'b1;
    write_addr[ch*3 +: 3] = a;
    write_data[ch*8 +: 8] = d;
  endtask

  task automatic do_init(input int ch, input logic [2:0] amt);
    init[ch] = 1'b1;
    init_amount[ch*3 +: 3] = amt;
  endtask

  task automatic do_append(input int ch, input logic [2:0] amt);
    append[ch] = 1'b1;
    append_amount[ch*3 +: 3] = amt;
  endtask

  task automatic test_reset();
    total++; if (empty !== 2'b11) begin bad++; $display("FAIL rst_empty got=%b exp=11", empty); end
    total++; if (full !== 2'b00) begin bad++; $display("FAIL rst_full got=%b exp=00", full); end
    total++; if (aempty !== 2'b11) begin bad++; $display("FAIL rst_aempty got=%b exp=11", aempty); end
    total++; if (afull !== 2'b00) begin bad++; $display("FAIL rst_afull got=%b exp=00", afull); end
    total++; if (pop_v !== 2'b00) begin bad++; $display("FAIL rst_pop_v got=%b exp=00", pop_v); end
    total++; if (fifo_depth !== 6'd0) begin bad++; $display("FAIL rst_depth got=%h exp=0", fifo_depth); end
    total++; if ({err_ovf, err_udf, err_unwr, err_addr} !== 8'h00) begin
      bad++; $display("FAIL rst_err got=%h exp=00", {err_ovf, err_udf, err_unwr, err_addr}); end
    total++; if ({rp, wp} !== 12'h000) begin bad++; $display("FAIL rst_ptr got=%h exp=000", {rp, wp}); end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 4; k++) begin do_push(0, 8'(8'h10 + k)); tick(); end
    total++; if (fd(0) !== 3'd4 || wpv(0) !== 3'd4) begin
      bad++; $display("FAIL wrap_fill got=cnt%0d wp%0d exp=cnt4 wp4", fd(0), wpv(0)); end
    for (int k = 0; k < 7; k++) begin
      total++; if (pd(0) !== 8'(8'h10 + k) || pop_v[0] !== 1'b1) begin
        bad++; $display("FAIL wrap_data[%0d] got=%h v=%b exp=%h v=1", k, pd(0), pop_v[0], 8'(8'h10 + k)); end
      pop[0] = 1'b1;
      if (k < 3) do_push(0, 8'(8'h14 + k));
      tick();
      if (k == 0) begin
        total++; if (wpv(0) !== 3'd0 || rpv(0) !== 3'd1) begin
          bad++; $display("FAIL wrap_wp got=wp%0d rp%0d exp=wp0 rp1", wpv(0), rpv(0)); end
      end
      if (k == 4) begin
        total++; if (rpv(0) !== 3'd0) begin bad++; $display("FAIL wrap_rp got=%0d exp=0", rpv(0)); end
      end
      total++; if (fd(1) !== 3'd0) begin bad++; $display("FAIL wrap_iso got=%0d exp=0", fd(1)); end
    end
    total++; if (empty[0] !== 1'b1 || rpv(0) !== 3'd2 || wpv(0) !== 3'd2) begin
      bad++; $display("FAIL wrap_end got=e%b rp%0d wp%0d exp=e1 rp2 wp2", empty[0], rpv(0), wpv(0)); end
    total++; if ({err_ovf, err_udf, err_unwr, err_addr} !== 8'h00) begin
      bad++; $display("FAIL wrap_err got=%h exp=00", {err_ovf, err_udf, err_unwr, err_addr}); end
  endtask

  task automatic test_full();
    for (int k = 0; k < 5; k++) begin do_push(1, 8'(8'h20 + k)); tick(); end
    total++; if (full[1] !== 1'b1 || fd(1) !== 3'd5 || afull[1] !== 1'b1 || wpv(1) !== 3'd0) begin
      bad++; $display("FAIL full_fill got=f%b cnt%0d af%b wp%0d exp=f1 cnt5 af1 wp0", full[1], fd(1), afull[1], wpv(1)); end
    do_push(1, 8'h25); pop[1] = 1'b1; tick();
    total++; if (fd(1) !== 3'd5 || err_ovf[1] !== 1'b0 || pd(1) !== 8'h21) begin
      bad++; $display("FAIL full_pushpop got=cnt%0d ovf%b hd%h exp=cnt5 ovf0 hd21", fd(1), err_ovf[1], pd(1)); end
    do_push(1, 8'h26); tick();
    total++; if (err_ovf[1] !== 1'b1 || fd(1) !== 3'd5) begin
      bad++; $display("FAIL full_drop got=ovf%b cnt%0d exp=ovf1 cnt5", err_ovf[1], fd(1)); end
    do_push(1, 8'h27); err_clr[1] = 1'b1; tick();
    total++; if (err_ovf[1] !== 1'b1) begin bad++; $display("FAIL full_clr_race got=%b exp=1", err_ovf[1]); end
    err_clr[1] = 1'b1; tick();
    total++; if (err_ovf[1] !== 1'b0) begin bad++; $display("FAIL full_clr got=%b exp=0", err_ovf[1]); end
    for (int k = 0; k < 5; k++) begin
      total++; if (pd(1) !== 8'(8'h21 + k)) begin
        bad++; $display("FAIL full_drain[%0d] got=%h exp=%h", k, pd(1), 8'(8'h21 + k)); end
      pop[1] = 1'b1; tick();
    end
    total++; if (empty[1] !== 1'b1 || fd(0) !== 3'd0) begin
      bad++; $display("FAIL full_end got=e1:%b cnt0:%0d exp=1,0", empty[1], fd(0)); end
  endtask

  task automatic test_empty();
    pop[0] = 1'b1; tick();
    total++; if (err_udf[0] !== 1'b1 || rpv(0) !== 3'd2 || err_ovf[0] !== 1'b0 || fd(0) !== 3'd0) begin
      bad++; $display("FAIL empty_udf got=udf%b rp%0d ovf%b cnt%0d exp=udf1 rp2 ovf0 cnt0",
                      err_udf[0], rpv(0), err_ovf[0], fd(0)); end
    do_push(0, 8'h33); pop[0] = 1'b1; tick();
    total++; if (fd(0) !== 3'd1 || pd(0) !== 8'h33 || pop_v[0] !== 1'b1 || rpv(0) !== 3'd2) begin
      bad++; $display("FAIL empty_pushpop got=cnt%0d hd%h v%b rp%0d exp=cnt1 hd33 v1 rp2",
                      fd(0), pd(0), pop_v[0], rpv(0)); end
    pop[0] = 1'b1; err_clr[0] = 1'b1; tick();
    total++; if (err_udf[0] !== 1'b0 || empty[0] !== 1'b1 || rpv(0) !== 3'd3) begin
      bad++; $display("FAIL empty_end got=udf%b e%b rp%0d exp=udf0 e1 rp3", err_udf[0], empty[0], rpv(0)); end
  endtask

  task automatic test_init_write();
    do_init(0, 3'd3); tick();
    total++; if (fd(0) !== 3'd3 || rpv(0) !== 3'd0 || wpv(0) !== 3'd3 || pop_v[0] !== 1'b0 || pk(0) !== 3'd3) begin
      bad++; $display("FAIL init_state got=cnt%0d rp%0d wp%0d v%b pk%0d exp=cnt3 rp0 wp3 v0 pk3",
                      fd(0), rpv(0), wpv(0), pop_v[0], pk(0)); end
    do_write(0, 3'd2, 8'hC2); tick();
    total++; if (pop_v[0] !== 1'b0) begin bad++; $display("FAIL init_w2 got=%b exp=0", pop_v[0]); end
    do_write(0, 3'd0, 8'hC0); tick();
    do_write(0, 3'd1, 8'hC1); tick();
    for (int k = 0; k < 3; k++) begin
      total++; if (pd(0) !== 8'(8'hC0 + k) || pop_v[0] !== 1'b1) begin
        bad++; $display("FAIL init_pop[%0d] got=%h v%b exp=%h v1", k, pd(0), pop_v[0], 8'(8'hC0 + k)); end
      pop[0] = 1'b1; tick();
    end
    total++; if (err_unwr[0] !== 1'b0 || empty[0] !== 1'b1) begin
      bad++; $display("FAIL init_end got=unwr%b e%b exp=unwr0 e1", err_unwr[0], empty[0]); end
    do_init(0, 3'd3); do_write(0, 3'd0, 8'hD0); tick();
    total++; if (pd(0) !== 8'hD0 || pop_v[0] !== 1'b1 || fd(0) !== 3'd3) begin
      bad++; $display("FAIL init_wr_same got=hd%h v%b cnt%0d exp=hdD0 v1 cnt3", pd(0), pop_v[0], fd(0)); end
    do_write(0, 3'd2, 8'hD2); tick();
    pop[0] = 1'b1; tick();
    total++; if (pop_v[0] !== 1'b0 || pd(0) !== 8'hC1) begin
      bad++; $display("FAIL init_hole got=v%b hd%h exp=v0 hdC1", pop_v[0], pd(0)); end
    pop[0] = 1'b1; tick();
    total++; if (err_unwr[0] !== 1'b1 || pd(0) !== 8'hD2 || pop_v[0] !== 1'b1) begin
      bad++; $display("FAIL init_unwr got=unwr%b hd%h v%b exp=unwr1 hdD2 v1", err_unwr[0], pd(0), pop_v[0]); end
    pop[0] = 1'b1; err_clr[0] = 1'b1; tick();
    total++; if (err_unwr[0] !== 1'b0 || empty[0] !== 1'b1) begin
      bad++; $display("FAIL init_clr got=unwr%b e%b exp=unwr0 e1", err_unwr[0], empty[0]); end
  endtask

  task automatic test_append_addr();
    for (int k = 0; k < 3; k++) begin do_push(0, 8'(8'hA0 + k)); tick(); end
    total++; if (fd(0) !== 3'd3 || wpv(0) !== 3'd1) begin
      bad++; $display("FAIL app_fill got=cnt%0d wp%0d exp=cnt3 wp1", fd(0), wpv(0)); end
    do_append(0, 3'd3); tick();
    total++; if (err_ovf[0] !== 1'b1 || fd(0) !== 3'd3 || wpv(0) !== 3'd1) begin
      bad++; $display("FAIL app_ovf got=ovf%b cnt%0d wp%0d exp=ovf1 cnt3 wp1", err_ovf[0], fd(0), wpv(0)); end
    do_append(0, 3'd2); err_clr[0] = 1'b1; tick();
    total++; if (err_ovf[0] !== 1'b0 || fd(0) !== 3'd5 || full[0] !== 1'b1 || wpv(0) !== 3'd3) begin
      bad++; $display("FAIL app_ok got=ovf%b cnt%0d f%b wp%0d exp=ovf0 cnt5 f1 wp3",
                      err_ovf[0], fd(0), full[0], wpv(0)); end
    do_append(0, 3'd0); tick();
    total++; if (err_ovf[0] !== 1'b0 || fd(0) !== 3'd5) begin
      bad++; $display("FAIL app_zero got=ovf%b cnt%0d exp=ovf0 cnt5", err_ovf[0], fd(0)); end
    do_write(0, 3'd6, 8'hEE); tick();
    total++; if (err_addr[0] !== 1'b1 || pd(0) !== 8'hA0 || pop_v[0] !== 1'b1) begin
      bad++; $display("FAIL app_addr got=ea%b hd%h v%b exp=ea1 hdA0 v1", err_addr[0], pd(0), pop_v[0]); end
    for (int k = 0; k < 3; k++) begin
      total++; if (pd(0) !== 8'(8'hA0 + k) || pop_v[0] !== 1'b1) begin
        bad++; $display("FAIL app_pop[%0d] got=%h v%b exp=%h v1", k, pd(0), pop_v[0], 8'(8'hA0 + k)); end
      pop[0] = 1'b1; tick();
    end
    total++; if (pop_v[0] !== 1'b0 || pd(0) !== 8'hC1) begin
      bad++; $display("FAIL app_rsv1 got=v%b hd%h exp=v0 hdC1", pop_v[0], pd(0)); end
    pop[0] = 1'b1; tick();
    total++; if (pop_v[0] !== 1'b0 || pd(0) !== 8'hD2) begin
      bad++; $display("FAIL app_rsv2 got=v%b hd%h exp=v0 hdD2", pop_v[0], pd(0)); end
    pop[0] = 1'b1; tick();
    total++; if (err_unwr[0] !== 1'b1 || empty[0] !== 1'b1) begin
      bad++; $display("FAIL app_unwr got=unwr%b e%b exp=unwr1 e1", err_unwr[0], empty[0]); end
    err_clr[0] = 1'b1; tick();
    total++; if ({err_ovf[0], err_udf[0], err_unwr[0], err_addr[0]} !== 4'h0) begin
      bad++; $display("FAIL app_clr got=%b exp=0000", {err_ovf[0], err_udf[0], err_unwr[0], err_addr[0]}); end
  endtask

  task automatic test_wm_reset();
    do_init(0, 3'd0); tick();
    total++; if (fd(0) !== 3'd0 || pk(0) !== 3'd0 || rpv(0) !== 3'd0 || wpv(0) !== 3'd0) begin
      bad++; $display("FAIL wm_init got=cnt%0d pk%0d rp%0d wp%0d exp=0 0 0 0", fd(0), pk(0), rpv(0), wpv(0)); end
    for (int n = 0; n <= 5; n++) begin
      total++; if (aempty[0] !== (n <= 1) || afull[0] !== (n >= 4) || fd(0) !== 3'(n)) begin
        bad++; $display("FAIL wm_step[%0d] got=ae%b af%b cnt%0d exp=ae%b af%b cnt%0d",
                        n, aempty[0], afull[0], fd(0), (n <= 1), (n >= 4), n); end
      if (n < 5) do_push(0, 8'(8'h50 + n));
      if (n == 0) do_push(1, 8'h61);
      tick();
    end
    total++; if (pk(0) !== 3'd5) begin bad++; $display("FAIL wm_peak got=%0d exp=5", pk(0)); end
    total++; if (fd(1) !== 3'd1 || pd(1) !== 8'h61 || pop_v[1] !== 1'b1) begin
      bad++; $display("FAIL wm_iso got=cnt%0d hd%h v%b exp=cnt1 hd61 v1", fd(1), pd(1), pop_v[1]); end
    do_push(0, 8'h5F); tick();
    total++; if (err_ovf[0] !== 1'b1) begin bad++; $display("FAIL wm_ovf got=%b exp=1", err_ovf[0]); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (empty !== 2'b11 || full !== 2'b00 || aempty !== 2'b11 || afull !== 2'b00) begin
      bad++; $display("FAIL rst_mid_flags got=e%b f%b ae%b af%b exp=e11 f00 ae11 af00", empty, full, aempty, afull); end
    total++; if (fifo_depth !== 6'd0 || peak_depth !== 6'd0 || pop_v !== 2'b00 || pop_data !== 16'h0) begin
      bad++; $display("FAIL rst_mid_state got=cnt%h pk%h v%b pd%h exp=0 0 00 0", fifo_depth, peak_depth, pop_v, pop_data); end
    total++; if ({err_ovf, err_udf, err_unwr, err_addr} !== 8'h00) begin
      bad++; $display("FAIL rst_mid_err got=%h exp=00", {err_ovf, err_udf, err_unwr, err_addr}); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    total++; if (empty !== 2'b11 || {rp, wp} !== 12'h000) begin
      bad++; $display("FAIL rst_release got=e%b ptr%h exp=e11 ptr000", empty, {rp, wp}); end
  endtask

  initial begin
    rst = 1'b1;
    low_wm = 3'd1;
    high_wm = 3'd4;
    push_data = '0; write_data = '0;
    init_amount = '0; append_amount = '0; write_addr = '0;
    clr_strobes();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    test_reset();
    test_wrap();
    test_full();
    test_empty();
    test_init_write();
    test_append_addr();
    test_wm_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
